// File: rtl/fmap_pad_streamer.sv
// fmap_pad_streamer: reads one NxN activation channel from on-chip memory and
// streams it row-major as an (N+2)x(N+2) frame with a one-pixel zero border.
// Each layer ends with a single clear beat (window_done/end_of_layer) that
// flushes the downstream 3x3 line buffer.
//
// Handshake: there is no ready signal downstream. hold=1 freezes the issue
// stage in the same cycle. The output stage is one register behind issue, so
// the beat issued just before hold rose still appears. mem_rd_data must be
// valid exactly one cycle after mem_rd_en, which lines up with the output
// register. window_done is only ever high together with wr_en.
module fmap_pad_streamer #(
  parameter int bitsize = 14,
  parameter int MAX_DIM = 112,
  parameter int ADDR_W  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [6:0]         layer_fifosize,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               hold,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [bitsize-1:0] mem_rd_data,
  output logic [bitsize-1:0] pixel_out,
  output logic               wr_en,
  output logic               window_done,
  output logic               end_of_layer,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // Position counters must reach N+1 for the trailing border.
  localparam int CW = $clog2(MAX_DIM + 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_FLUSH  = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     r_q, r_d, c_q, c_d;
  logic              wr_q, wr_d;
  logic              tag_q, tag_d;   // registered beat came from memory
  logic              clr_q, clr_d;   // registered beat is the clear beat
  logic              err_q, err_d;

  logic [CW-1:0]     n_p1;
  logic              legal_n;
  logic              interior;

  assign n_p1     = CW'(n_q) + CW'(1);
  assign legal_n  = (layer_fifosize == 7'd112) || (layer_fifosize == 7'd56) ||
                    (layer_fifosize == 7'd28);
  assign interior = (r_q != '0) && (r_q != n_p1) && (c_q != '0) && (c_q != n_p1);

  // Next-state, issue-stage control and read strobe.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    addr_d    = addr_q;
    r_d       = r_q;
    c_d       = c_q;
    wr_d      = 1'b0;
    tag_d     = 1'b0;
    clr_d     = 1'b0;
    err_d     = 1'b0;
    mem_rd_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (legal_n) begin
            n_d     = layer_fifosize;
            addr_d  = base_addr;
            r_d     = '0;
            c_d     = '0;
            state_d = S_STREAM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (!hold) begin
          wr_d  = 1'b1;
          tag_d = interior;
          if (interior) begin
            mem_rd_en = 1'b1;
            addr_d    = addr_q + ADDR_W'(1);
          end
          if (c_q == n_p1) begin
            c_d = '0;
            if (r_q == n_p1) state_d = S_FLUSH;
            else             r_d     = r_q + CW'(1);
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        if (!hold) begin
          wr_d    = 1'b1;
          clr_d   = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;   // clear beat is on the outputs this cycle
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and output-stage registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      wr_q    <= 1'b0;
      tag_q   <= 1'b0;
      clr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      r_q     <= r_d;
      c_q     <= c_d;
      wr_q    <= wr_d;
      tag_q   <= tag_d;
      clr_q   <= clr_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr     = mem_rd_en ? addr_q : '0;
  assign pixel_out    = tag_q ? mem_rd_data : '0;
  assign wr_en        = wr_q;
  assign window_done  = clr_q;
  assign end_of_layer = clr_q;
  assign busy         = (state_q == S_STREAM) || (state_q == S_FLUSH) ||
                        (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign err          = err_q;

endmodule

// File: tb/tb_fmap_pad_streamer.sv
// Bench for fmap_pad_streamer: memory model, per-scenario tasks and a
// reference model that builds the padded frame directly from N and base.
module tb_fmap_pad_streamer;
  localparam int BS = 14;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [6:0]    layer_fifosize = '0;
  logic [AW-1:0] base_addr = '0;
  logic [BS-1:0] mem_rd_data = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [BS-1:0] pixel_out;
  logic          wr_en, window_done, end_of_layer, busy, done, err;

  fmap_pad_streamer #(.bitsize(BS), .MAX_DIM(112), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .layer_fifosize(layer_fifosize),
    .base_addr(base_addr), .hold(hold), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .pixel_out(pixel_out),
    .wr_en(wr_en), .window_done(window_done), .end_of_layer(end_of_layer),
    .busy(busy), .done(done), .err(err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Activation memory: one-cycle read latency.
  logic [BS-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  int checks = 0;
  int failures = 0;

  // Scoreboard
  logic [BS-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [BS-1:0] got_pix[$];
  bit            got_wd[$];
  bit            got_eol[$];
  logic [AW-1:0] got_addr[$];
  int first_wr_cyc, last_data_cyc, clear_cyc, done_cyc, done_cnt;
  int wd_bad, busy_cnt, err_cnt;
  bit timed_out;

  task automatic fill_mem(input bit identity);
    for (int i = 0; i < (1 << AW); i++) mem[i] = identity ? BS'(i) : BS'($urandom);
  endtask

  // Reference: padded frame row-major, interior read from base+(r-1)*N+(c-1).
  task automatic build_model(input int n, input int base);
    logic [AW-1:0] a;
    exp_q.delete();
    exp_addr_q.delete();
    for (int r = 0; r < n + 2; r++)
      for (int c = 0; c < n + 2; c++)
        if (r >= 1 && r <= n && c >= 1 && c <= n) begin
          a = AW'(base + (r - 1) * n + (c - 1));
          exp_addr_q.push_back(a);
          exp_q.push_back(mem[a]);
        end else begin
          exp_q.push_back('0);
        end
  endtask

  function automatic int pix_mismatch();
    int m = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_pix.size() || got_pix[i] !== exp_q[i] || got_wd[i]) m++;
    return m;
  endfunction

  function automatic int addr_mismatch();
    int m = 0;
    if (got_addr.size() != exp_addr_q.size()) m++;
    for (int i = 0; i < exp_addr_q.size(); i++)
      if (i >= got_addr.size() || got_addr[i] !== exp_addr_q[i]) m++;
    return m;
  endfunction

  function automatic int wd_total();
    int s = 0;
    foreach (got_wd[i]) s += int'(got_wd[i]) + int'(got_eol[i]);
    return s;
  endfunction

  // Driver: one channel. Samples outputs on negedge and drives the next edge.
  task automatic run_channel(input int n, input int base, input int hold_beat,
                             input int hold_len, input int flush_hold,
                             input int ign_cyc, input int rst_beat,
                             input bit start_at_done);
    int cyc, beats, hold_left, budget;
    bit mid_used, fl_used, fin;
    got_pix.delete(); got_wd.delete(); got_eol.delete(); got_addr.delete();
    first_wr_cyc = -1; last_data_cyc = -1; clear_cyc = -1; done_cyc = -1;
    done_cnt = 0; wd_bad = 0; busy_cnt = 0; err_cnt = 0; timed_out = 0;
    beats = 0; hold_left = 0; mid_used = 0; fl_used = 0; fin = 0;
    budget = (n + 2) * (n + 2) + 64 + hold_len + flush_hold;
    @(negedge clk);
    layer_fifosize = 7'(n);
    base_addr = AW'(base);
    start = 1'b1;
    cyc = 0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (wr_en) begin
        got_pix.push_back(pixel_out);
        got_wd.push_back(window_done);
        got_eol.push_back(end_of_layer);
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        if (window_done) clear_cyc = cyc;
        else last_data_cyc = cyc;
        beats++;
      end
      if ((window_done || end_of_layer) && !wr_en) wd_bad++;
      if (mem_rd_en) got_addr.push_back(mem_addr);
      if (err) err_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (rst_beat > 0 && beats == rst_beat) begin
        rst = 1'b0;
        fin = 1;
      end
      hold = 1'b0;
      if (hold_len > 0 && !mid_used && beats == hold_beat) begin
        hold_left = hold_len; mid_used = 1;
      end
      if (flush_hold > 0 && !fl_used && beats == (n + 2) * (n + 2)) begin
        hold_left = flush_hold; fl_used = 1;
      end
      if (hold_left > 0) begin hold = 1'b1; hold_left--; end
      if (cyc == ign_cyc) begin
        start = 1'b1; layer_fifosize = 7'd28; base_addr = AW'(77);
      end
      if (done && start_at_done) begin
        start = 1'b1; layer_fifosize = 7'(n); base_addr = AW'(base);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) fin = 1;
      if (cyc > budget) begin timed_out = 1; fin = 1; end
    end
    hold = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wr_en !== 1'b0 || window_done !== 1'b0 || end_of_layer !== 1'b0) begin
      failures++; $display("FAIL reset_stream_outs got wr=%b wd=%b eol=%b want 0", wr_en, window_done, end_of_layer); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL reset_status got busy=%b done=%b err=%b want 0", busy, done, err); end
    checks++; if (mem_rd_en !== 1'b0 || mem_addr !== '0 || pixel_out !== '0) begin
      failures++; $display("FAIL reset_mem got rd=%b addr=%0d pix=%0d want 0", mem_rd_en, mem_addr, pixel_out); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_n28();
    int m;
    fill_mem(0);
    build_model(28, 0);
    run_channel(28, 0, -1, 0, 0, -1, 0, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout got timeout want done"); end
    checks++; if (first_wr_cyc !== 2) begin failures++; $display("FAIL basic_latency got %0d want 2", first_wr_cyc); end
    checks++; if (got_pix.size() !== 901) begin failures++; $display("FAIL basic_beats got %0d want 901", got_pix.size()); end
    m = pix_mismatch();
    checks++; if (m !== 0) begin failures++; $display("FAIL basic_pixels got %0d mismatches want 0", m); end
    m = addr_mismatch();
    checks++; if (m !== 0 || got_addr.size() !== 784) begin
      failures++; $display("FAIL basic_addrs got %0d mismatches, %0d reads want 0, 784", m, got_addr.size()); end
    checks++; if (got_pix.size() != 901 || got_wd[900] !== 1'b1 || got_eol[900] !== 1'b1 || got_pix[900] !== '0 || wd_total() !== 2) begin
      failures++; $display("FAIL basic_clear_beat got wd_total=%0d want 2 on final zero beat", wd_total()); end
    checks++; if (done_cyc !== clear_cyc + 1 || done_cnt !== 1) begin
      failures++; $display("FAIL basic_done got cyc=%0d cnt=%0d want cyc=%0d cnt=1", done_cyc, done_cnt, clear_cyc + 1); end
    checks++; if (busy_cnt !== clear_cyc) begin failures++; $display("FAIL basic_busy got %0d want %0d", busy_cnt, clear_cyc); end
    checks++; if (clear_cyc - last_data_cyc !== 1 || wd_bad !== 0) begin
      failures++; $display("FAIL basic_clear_gap got %0d bad=%0d want 1 bad=0", clear_cyc - last_data_cyc, wd_bad); end
  endtask

  task automatic test_content_n56();
    int m, nz;
    fill_mem(1);
    build_model(56, 1000);
    run_channel(56, 1000, -1, 0, 0, -1, 0, 0);
    checks++; if (got_pix.size() !== 3365) begin failures++; $display("FAIL n56_beats got %0d want 3365", got_pix.size()); end
    if (got_pix.size() == 3365) begin
      checks++; if (got_pix[58] !== 14'd0 || got_pix[59] !== 14'd1000 || got_pix[114] !== 14'd1055 || got_pix[115] !== 14'd0) begin
        failures++; $display("FAIL n56_row1 got %0d %0d %0d %0d want 0 1000 1055 0", got_pix[58], got_pix[59], got_pix[114], got_pix[115]); end
      checks++; if (got_pix[3304] !== 14'd4135 || got_pix[3305] !== 14'd0) begin
        failures++; $display("FAIL n56_row56 got %0d %0d want 4135 0", got_pix[3304], got_pix[3305]); end
      nz = 0;
      for (int i = 0; i < 58; i++) begin
        if (got_pix[i] !== '0) nz++;
        if (got_pix[3306 + i] !== '0) nz++;
      end
      checks++; if (nz !== 0) begin failures++; $display("FAIL n56_border_rows got %0d nonzero want 0", nz); end
    end
    m = pix_mismatch();
    checks++; if (m !== 0) begin failures++; $display("FAIL n56_pixels got %0d mismatches want 0", m); end
  endtask

  task automatic test_back_pressure();
    int m;
    fill_mem(0);
    build_model(28, 3000);
    run_channel(28, 3000, 10 * 30 + 15, 5, 3, -1, 0, 0);
    checks++; if (timed_out || got_pix.size() !== 901) begin
      failures++; $display("FAIL bp_beats got %0d timeout=%0d want 901", got_pix.size(), timed_out); end
    m = pix_mismatch();
    checks++; if (m !== 0) begin failures++; $display("FAIL bp_pixels got %0d mismatches want 0", m); end
    m = addr_mismatch();
    checks++; if (m !== 0) begin failures++; $display("FAIL bp_addrs got %0d mismatches want 0", m); end
    checks++; if (clear_cyc - last_data_cyc !== 4) begin
      failures++; $display("FAIL bp_clear_delay got %0d want 4", clear_cyc - last_data_cyc); end
    checks++; if (first_wr_cyc !== 2 || done_cyc !== clear_cyc + 1) begin
      failures++; $display("FAIL bp_timing got first=%0d done=%0d want 2 %0d", first_wr_cyc, done_cyc, clear_cyc + 1); end
  endtask

  task automatic test_illegal_and_ignore();
    int m, b;
    @(negedge clk);
    layer_fifosize = 7'd100; base_addr = AW'(5); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (err !== 1'b1 || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      failures++; $display("FAIL illegal_err got err=%b busy=%b rd=%b want 1 0 0", err, busy, mem_rd_en); end
    @(negedge clk);
    checks++; if (err !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      failures++; $display("FAIL illegal_after got err=%b busy=%b rd=%b want 0 0 0", err, busy, mem_rd_en); end
    fill_mem(0);
    b = $urandom_range(0, 2000);
    build_model(112, b);
    run_channel(112, b, -1, 0, 0, 500, 0, 1);
    checks++; if (got_pix.size() !== 12997 || timed_out) begin
      failures++; $display("FAIL ignore_beats got %0d timeout=%0d want 12997", got_pix.size(), timed_out); end
    m = addr_mismatch();
    checks++; if (m !== 0) begin failures++; $display("FAIL ignore_addrs got %0d mismatches want 0", m); end
    m = pix_mismatch();
    checks++; if (m !== 0) begin failures++; $display("FAIL ignore_pixels got %0d mismatches want 0", m); end
    checks++; if (busy_cnt !== clear_cyc || err_cnt !== 0) begin
      failures++; $display("FAIL ignore_busy got busy=%0d err=%0d want %0d 0", busy_cnt, err_cnt, clear_cyc); end
  endtask

  task automatic test_reset_mid();
    int m, b;
    fill_mem(0);
    run_channel(112, 200, -1, 0, 0, -1, 400, 0);
    @(negedge clk);
    checks++; if (wr_en !== 1'b0 || window_done !== 1'b0 || end_of_layer !== 1'b0 || pixel_out !== '0) begin
      failures++; $display("FAIL rstmid_stream got wr=%b wd=%b eol=%b pix=%0d want 0", wr_en, window_done, end_of_layer, pixel_out); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0 || mem_addr !== '0) begin
      failures++; $display("FAIL rstmid_ctrl got busy=%b done=%b rd=%b addr=%0d want 0", busy, done, mem_rd_en, mem_addr); end
    checks++; if (wd_total() !== 0) begin failures++; $display("FAIL rstmid_no_clear got %0d want 0", wd_total()); end
    rst = 1'b1;
    @(negedge clk);
    b = $urandom_range(0, 15000);
    build_model(28, b);
    run_channel(28, b, -1, 0, 0, -1, 0, 0);
    m = pix_mismatch() + addr_mismatch();
    checks++; if (m !== 0 || got_pix.size() !== 901 || first_wr_cyc !== 2) begin
      failures++; $display("FAIL rstmid_restart got mism=%0d beats=%0d first=%0d want 0 901 2", m, got_pix.size(), first_wr_cyc); end
  endtask

  task automatic test_back_to_back();
    int m, b1, b2;
    fill_mem(0);
    b1 = $urandom_range(0, 3000);
    b2 = $urandom_range(0, 15000);
    build_model(112, b1);
    run_channel(112, b1, -1, 0, 0, -1, 0, 0);
    m = pix_mismatch() + addr_mismatch();
    checks++; if (m !== 0 || got_pix.size() !== 12997 || got_addr.size() == 0 || got_addr[0] !== AW'(b1)) begin
      failures++; $display("FAIL b2b_first got mism=%0d beats=%0d want 0 12997", m, got_pix.size()); end
    build_model(28, b2);
    run_channel(28, b2, -1, 0, 0, -1, 0, 0);
    m = pix_mismatch() + addr_mismatch();
    checks++; if (m !== 0 || got_pix.size() !== 901 || got_addr.size() == 0 || got_addr[0] !== AW'(b2)) begin
      failures++; $display("FAIL b2b_second got mism=%0d beats=%0d want 0 901", m, got_pix.size()); end
    checks++; if (first_wr_cyc !== 2 || done_cnt !== 1) begin
      failures++; $display("FAIL b2b_timing got first=%0d done_cnt=%0d want 2 1", first_wr_cyc, done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_n28();
    test_content_n56();
    test_back_pressure();
    test_illegal_and_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
